// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for N_REQ requesters with grant hold, release handshake and hold timeout.
// The rotating-priority search starts at ptr, which advances past each released grantee.
module rr_grant_arbiter #(
  parameter int unsigned N_REQ    = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned MAX_HOLD = 12,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [IDX_W-1:0] winner_c;
  logic             found_c;
  logic [IDX_W-1:0] cand_c;
  logic             release_c;

  // Rotating-priority search: first set request at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    cand_c   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_c = ptr_q + IDX_W'(i);
      if (!found_c && req[cand_c]) begin
        winner_c = cand_c;
        found_c  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  // Release priority: done, then withdrawn request, then hold limit (the only case flagged as timeout).
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    release_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (ena && found_c) begin
          grant_d           = '0;
          grant_d[winner_c] = 1'b1;
          idx_d             = winner_c;
          valid_d           = 1'b1;
          hold_d            = HOLD_W'(1);
          state_d           = GRANT;
        end
      end
      GRANT: begin
        release_c = done || !req[idx_q] || (hold_q == HOLD_W'(MAX_HOLD));
        if (release_c) begin
          timeout_d = !done && req[idx_q];
          grant_d   = '0;
          valid_d   = 1'b0;
          ptr_d     = idx_q + IDX_W'(1);
          state_d   = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;
  assign busy        = valid_q;

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among 16 requesters.
- Request lines come from the same ui_in/uio_in pins that feed the priority encoder: ui_in is requesters 0-7, uio_in is requesters 8-15.
- The plain fixed-priority encode is replaced by a rotating-priority search with grant hold, release handshake and a hold-timeout, so no requester can starve the others.
- Instantiated inside the top-level wrapper. Outputs drive uo_out (index/valid) and status.

Parameters:
- N_REQ, 16, number of requesters; must be a power of two ≥ 2.
- IDX_W, 4, width of encoded grant index (log2 N_REQ).
- MAX_HOLD, 12, maximum consecutive cycles a grant is held before forced release; range 1..2^HOLD_W-1.
- HOLD_W, 4, width of the hold counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- ena  input  1  arbiter enable; 0 blocks new grants only.
- req  input  N_REQ  request vector; bit i high = requester i wants the resource.
- done  input  1  current grantee releases the resource this cycle.
- grant  output  N_REQ  one-hot grant vector, registered.
- grant_idx  output  IDX_W  binary index of the current grantee, registered.
- grant_valid  output  1  high while a grant is held.
- timeout  output  1  single-cycle pulse when a grant is force-released by MAX_HOLD.
- busy  output  1  high in GRANT state; equals grant_valid.

Behaviour:
- Reset (rst_n=0, asynchronous) sets: grant=0, grant_idx=0, grant_valid=0, timeout=0, busy=0, state=IDLE, ptr=0, hold_cnt=0.
- State IDLE:
  - Condition for a grant: ena=1 and req≠0.
  - Winner = first set req bit searching upward from index ptr, wrapping N_REQ-1 → 0.
  - On that edge: grant=onehot(winner), grant_idx=winner, grant_valid=1, hold_cnt=1, state → GRANT.
  - Latency: req sampled at edge k gives grant visible after edge k. No combinational path from req to outputs.
- State GRANT: each edge, evaluate the release conditions in this priority order:
  - (a) done=1 → release.
  - (b) req[grant_idx]=0 → release (requester withdrew).
  - (c) hold_cnt==MAX_HOLD → release and timeout=1 for that one cycle.
  - Otherwise hold_cnt+1, grant unchanged.
- On any release:
  - grant=0, grant_valid=0.
  - grant_idx holds its last value.
  - ptr = (grant_idx+1) mod N_REQ, state → IDLE.
- At least one dead cycle always separates consecutive grants, so grant_valid is low for ≥1 cycle between any two grants, including re-grant to the same requester.
- done while in IDLE is ignored.
- timeout is cleared on every edge where it is not set.
- ena=0 during GRANT does not cut the grant. It only prevents the next IDLE→GRANT.
- Simultaneous done=1 and hold_cnt==MAX_HOLD: treated as a normal release, timeout stays 0.
- Request changes for other requesters during GRANT have no effect until the next IDLE.
- ptr wrap: ptr=15 with req=0x0001 grants index 0.
- Reset asserted mid-grant clears everything immediately, without waiting for a clock edge. After reset release, arbitration restarts from ptr=0.
- The hold counter never exceeds MAX_HOLD. No overflow is reachable.

Test Plan:
- Reset then req=0x8080 (ui_in=0x80, uio_in=0x80), ena=1 → after 1 edge: grant_idx=7, grant=0x0080, grant_valid=1; assert done 3 cycles later → grant_valid=0 next edge, ptr=8.
- Rotation: req=0xFFFF held, done pulsed each cycle grant is up → grant_idx sequence 0,1,2,...,15,0 with a grant_valid=0 gap between each.
- Timeout: req=0x0004 held, no done → grant held exactly 12 cycles; timeout=1 on the release edge, then 0; re-granted to index 2 after one idle cycle.
- Withdraw and wrap: grantee 15 drops req with req=0x0001 also pending → release, ptr wraps to 0, next grant_idx=0.
- ena gating: grant active, ena dropped → grant persists until done; with ena=0 no new grant is issued; raising ena resumes arbitration.
- Async reset mid-grant: rst_n low between clock edges → all outputs 0 immediately; after release, req=0x0300 → grant_idx=8.
